// File: rtl/playfield_board.sv
// Tetris playfield store: occupancy and colour per cell, piece locking,
// bottom-up line clearing, collision probes and a registered display read port.
module playfield_board #(
   parameter int COLS = 10,
   parameter int ROWS = 20,
   parameter int XW   = 4,
   parameter int YW   = 5,
   parameter int CW   = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [4*XW-1:0] probe_x,
   input  logic [4*YW-1:0] probe_y,
   output logic            collide,
   input  logic            lock_valid,
   output logic            lock_ready,
   input  logic [4*XW-1:0] lock_x,
   input  logic [4*YW-1:0] lock_y,
   input  logic [CW-1:0]   lock_type,
   input  logic [XW-1:0]   rd_x,
   input  logic [YW-1:0]   rd_y,
   output logic            rd_occ,
   output logic [CW-1:0]   rd_type,
   output logic            busy,
   output logic            settle_done,
   output logic [2:0]      rows_cleared,
   output logic [15:0]     total_lines,
   output logic            game_over
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   localparam logic [XW:0]   COLS_LIM = (XW+1)'(COLS);
   localparam logic [YW:0]   ROWS_LIM = (YW+1)'(ROWS);
   localparam logic [YW-1:0] LAST_ROW = YW'(ROWS-1);

   logic [COLS-1:0] occ_reg  [ROWS];
   logic [CW-1:0]   type_reg [ROWS][COLS];

   logic [1:0]    state_reg;
   logic [YW-1:0] scan_r_reg;
   logic [YW-1:0] shift_s_reg;
   logic [2:0]    clr_cnt_reg;
   logic          settle_done_reg;
   logic [2:0]    rows_cleared_reg;
   logic [15:0]   total_lines_reg;
   logic          game_over_reg;
   logic          rd_occ_reg;
   logic [CW-1:0] rd_type_reg;

   logic [XW-1:0] probe_cx [4];
   logic [YW-1:0] probe_cy [4];
   logic [XW-1:0] lock_cx  [4];
   logic [YW-1:0] lock_cy  [4];
   logic [3:0]    probe_hit;
   logic [3:0]    lock_in;

   logic          lock_fire;
   logic          row_full;
   logic          rd_in;
   logic [16:0]   total_sum;

   // Per-cell unpacking and range checks for both the probe and lock ports.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cell
         logic probe_in;
         assign probe_cx[gi]  = probe_x[gi*XW +: XW];
         assign probe_cy[gi]  = probe_y[gi*YW +: YW];
         assign lock_cx[gi]   = lock_x[gi*XW +: XW];
         assign lock_cy[gi]   = lock_y[gi*YW +: YW];
         assign probe_in      = ({1'b0, probe_cx[gi]} < COLS_LIM) &&
                                ({1'b0, probe_cy[gi]} < ROWS_LIM);
         assign probe_hit[gi] = probe_in ? occ_reg[probe_cy[gi]][probe_cx[gi]] : 1'b1;
         assign lock_in[gi]   = ({1'b0, lock_cx[gi]} < COLS_LIM) &&
                                ({1'b0, lock_cy[gi]} < ROWS_LIM);
      end
   endgenerate

   assign busy         = (state_reg != ST_IDLE);
   assign lock_ready   = (state_reg == ST_IDLE) && !game_over_reg;
   assign lock_fire    = lock_valid && lock_ready;
   assign collide      = (|probe_hit) || busy;
   assign row_full     = &occ_reg[scan_r_reg];
   assign rd_in        = ({1'b0, rd_x} < COLS_LIM) && ({1'b0, rd_y} < ROWS_LIM);
   assign total_sum    = {1'b0, total_lines_reg} + {14'd0, clr_cnt_reg};

   assign settle_done  = settle_done_reg;
   assign rows_cleared = rows_cleared_reg;
   assign total_lines  = total_lines_reg;
   assign game_over    = game_over_reg;
   assign rd_occ       = rd_occ_reg;
   assign rd_type      = rd_type_reg;

   // Cell array: written by a lock in IDLE, moved down one row per SHIFT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < ROWS; r++) begin
            occ_reg[r] <= '0;
            for (int c = 0; c < COLS; c++) type_reg[r][c] <= '0;
         end
      end else if (state_reg == ST_IDLE) begin
         if (lock_fire) begin
            for (int k = 0; k < 4; k++) begin
               if (lock_in[k]) begin
                  occ_reg[lock_cy[k]][lock_cx[k]]  <= 1'b1;
                  type_reg[lock_cy[k]][lock_cx[k]] <= lock_type;
               end
            end
         end
      end else if (state_reg == ST_SHIFT) begin
         if (shift_s_reg != '0) begin
            occ_reg[shift_s_reg] <= occ_reg[shift_s_reg - 1'b1];
            for (int c = 0; c < COLS; c++)
               type_reg[shift_s_reg][c] <= type_reg[shift_s_reg - 1'b1][c];
         end else begin
            occ_reg[0] <= '0;
            for (int c = 0; c < COLS; c++) type_reg[0][c] <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         scan_r_reg       <= '0;
         shift_s_reg      <= '0;
         clr_cnt_reg      <= '0;
         settle_done_reg  <= 1'b0;
         rows_cleared_reg <= '0;
         total_lines_reg  <= '0;
         game_over_reg    <= 1'b0;
      end else begin
         settle_done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (lock_fire) begin
                  scan_r_reg  <= LAST_ROW;
                  clr_cnt_reg <= '0;
                  state_reg   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (row_full) begin
                  shift_s_reg <= scan_r_reg;
                  clr_cnt_reg <= clr_cnt_reg + 3'd1;
                  state_reg   <= ST_SHIFT;
               end else if (scan_r_reg != '0) begin
                  scan_r_reg <= scan_r_reg - 1'b1;
               end else begin
                  state_reg        <= ST_IDLE;
                  settle_done_reg  <= 1'b1;
                  rows_cleared_reg <= clr_cnt_reg;
                  total_lines_reg  <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                  if (|occ_reg[0]) game_over_reg <= 1'b1;
               end
            end
            ST_SHIFT: begin
               // Scan row stays put so the row that fell into it is retested.
               if (shift_s_reg != '0) shift_s_reg <= shift_s_reg - 1'b1;
               else                   state_reg   <= ST_SCAN;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_occ_reg  <= 1'b0;
         rd_type_reg <= '0;
      end else if (rd_in) begin
         rd_occ_reg  <= occ_reg[rd_y][rd_x];
         rd_type_reg <= type_reg[rd_y][rd_x];
      end else begin
         rd_occ_reg  <= 1'b0;
         rd_type_reg <= '0;
      end
   end

endmodule
